spi_ram_ctrl: RTL and testbench
===============================

# spi_ram_ctrl

Command sequencer between the SPI slave's parallel side and a single-port byte RAM. It decodes each 10-bit word delivered on `rx_valid`/`rx_data` into a write-address, write-data, read-address or read-data operation. It drives the RAM port with correct enable/latency timing and returns read bytes to the SPI slave on `tx_valid`/`tx_data`, holding them stable long enough for serialisation.

## Interface
- `ADDR_SIZE`, 8: RAM address width.
- `RD_LAT`, 1: RAM read latency in cycles, from `mem_en` to valid `mem_dout`; legal range 1–4.
- `TX_HOLD`, 9: number of cycles `tx_valid` stays high per returned byte; must be ≥ 9.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `rx_data` in 10: bits [9:8] are the opcode; bits [7:0] are the payload.
- `tx_valid` out 1: `tx_data` valid for the SPI slave.
- `tx_data` out 8: read byte.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable; qualified by `mem_en`.
- `mem_addr` out `ADDR_SIZE`: RAM address.
- `mem_din` out 8: RAM write data.
- `mem_dout` in 8: RAM read data.
- `busy` out 1: controller cannot accept a command.
- `err_cnt` out 8: dropped/illegal command count; present only with `SPI_RAM_CTRL_ERR_CNT_EN`.

## Operation
- Opcodes:
  - 00 WR_ADDR: latch the payload into `wr_addr`.
  - 01 WR_DATA: write the payload to `wr_addr`.
  - 10 RD_ADDR: latch the payload into `rd_addr` and set `rd_armed`.
  - 11 RD_DATA: read `rd_addr`, return the byte, then clear `rd_armed`.
- Address payload is truncated or zero-extended to `ADDR_SIZE`.
- No address auto-increment.
- FSM states:
  - IDLE: `busy`=0. Accept `rx_valid`:
    - 00/10: register update only, stay in IDLE.
    - 01: go to WRITE.
    - 11 with `rd_armed`=1: go to RD_ISSUE.
    - 11 with `rd_armed`=0: illegal; ignored, stay in IDLE, counted as an error.
  - WRITE: `mem_en`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_din`=payload, for one cycle, then IDLE.
  - RD_ISSUE: `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`, for one cycle. Load the wait counter with `RD_LAT`-1, then RD_WAIT.
  - RD_WAIT: decrement the counter. When it is 0, register `mem_dout` into `tx_data`, load the hold counter with `TX_HOLD`, then TX_HOLD.
  - TX_HOLD: `tx_valid`=1. Decrement the counter; at 1, go to IDLE, with `tx_valid` low the next cycle. `rd_armed` clears on entry to TX_HOLD.
- `busy`=1 in WRITE, RD_ISSUE, RD_WAIT and TX_HOLD.
- `rx_valid` while `busy`=1 is dropped (no state change) and counted as an error.
- `tx_data` holds its last value after `tx_valid` falls.
- `mem_en`, `mem_we`, `mem_din` and `mem_addr` are 0 whenever no access is in progress.
- Reset values: every output and internal register is 0, state is IDLE, `rd_armed`=0.
- Reset mid-operation: all state clears asynchronously and `tx_valid` drops immediately. A RAM write already strobed is not undone.

## Timing
- All outputs are registered.
- Write: `rx_valid` at cycle T → `mem_en`/`mem_we` high at cycle T+1 only. `busy` is high at T+1 and low at T+2.
- Address commands: the new address is effective for a command accepted at T+1 or later.
- Read: `rx_valid` (11) at T → `mem_en` at T+1 → `mem_dout` sampled at T+1+`RD_LAT`.
  - `tx_valid` high from T+2+`RD_LAT` through T+1+`RD_LAT`+`TX_HOLD`.
  - `busy` low at T+2+`RD_LAT`+`TX_HOLD`.
- Back-to-back command: the earliest next accept is the first cycle with `busy`=0.

## Configuration
- `SPI_RAM_CTRL_ERR_CNT_EN` defined:
  - 8-bit `err_cnt` port is present.
  - It increments on each dropped (`busy`) or illegal (unarmed RD_DATA) command.
  - It saturates at 255 and resets to 0.
- `SPI_RAM_CTRL_ERR_CNT_EN` undefined:
  - Port and counter are absent.
  - Errors are silently ignored; all other behaviour is identical.

## Structure
- Shared package `spi_ram_pkg`:
  - opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11;
  - state encodings IDLE/WRITE/RD_ISSUE/RD_WAIT/TX_HOLD;
  - command word width 10.
- One sub-module: `spi_ram_ctrl_cnt`, a loadable down-counter reused for the RD_WAIT and TX_HOLD counts. Everything else stays flat.

## Test plan
- WR_ADDR 0x3C, then WR_DATA 0xA5 → one cycle with `mem_en`=`mem_we`=1, `mem_addr`=0x3C, `mem_din`=0xA5, at T+1 of the data strobe.
- RD_ADDR 0x3C, then RD_DATA with RAM returning 0xA5 and `RD_LAT`=1:
  - `mem_en`=1, `mem_we`=0 at T+1;
  - `tx_data`=0xA5 with `tx_valid` high for exactly 9 cycles starting at T+3;
  - `busy` low at T+12.
- RD_DATA with no prior RD_ADDR → no `mem_en`, no `tx_valid`; `err_cnt` becomes 1 (macro on).
- `rx_valid` during TX_HOLD → command ignored, byte stream unaffected, `err_cnt` increments.
- `rst_n` pulled low during TX_HOLD → `tx_valid`, `busy` and `tx_data` are 0 immediately. A following RD_DATA without a new RD_ADDR is treated as illegal.
- Repeat the read with `RD_LAT`=3 → `tx_valid` rises at T+5.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command sequencer:
// command word width, opcode encodings, FSM state encoding and a
// helper that sizes the shared wait/hold down-counter.
package spi_ram_pkg;

    localparam int CMD_W = 10;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_TX_HOLD  = 3'd4
    } state_e;

    // Width needed to hold the larger of the read latency and the hold count.
    function automatic int cnt_width(input int rd_lat, input int tx_hold);
        int max_v;
        max_v = (tx_hold > rd_lat) ? tx_hold : rd_lat;
        return (max_v < 2) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_cnt.sv
// Loadable down-counter shared by the read-latency wait and the
// tx_valid hold window. Load wins over decrement; the count never
// wraps below zero. Flags are decoded from the registered count.
module spi_ram_ctrl_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);

    logic [WIDTH-1:0] count_r;

    // Count register: load a new value or step down towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign is_zero = (count_r == '0);
    assign is_one  = (count_r == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command sequencer between an SPI slave's parallel side and a
// single-port byte RAM. Decodes 10-bit command words, drives the RAM
// strobes with the configured read latency and presents read bytes on
// tx_valid/tx_data for TX_HOLD cycles.
// Optional feature: define SPI_RAM_CTRL_ERR_CNT_EN to add the saturating
// err_cnt port counting dropped (busy) and illegal (unarmed read) commands.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int RD_LAT    = 1,
    parameter int TX_HOLD   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [CMD_W-1:0]     rx_data,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [7:0]           mem_din,
    input  logic [7:0]           mem_dout,
`ifdef SPI_RAM_CTRL_ERR_CNT_EN
    output logic [7:0]           err_cnt,
`endif
    output logic                 busy
);

    localparam int CNT_W = cnt_width(RD_LAT, TX_HOLD);

    state_e               state_r;
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] rd_addr_r;
    logic                 rd_armed_r;

    logic [1:0]           opcode_s;
    logic [7:0]           payload_s;
    logic [ADDR_SIZE-1:0] pay_addr_s;

    logic                 cnt_load_s;
    logic [CNT_W-1:0]     cnt_val_s;
    logic                 cnt_dec_s;
    logic                 cnt_zero_s;
    logic                 cnt_one_s;

    assign opcode_s   = rx_data[9:8];
    assign payload_s  = rx_data[7:0];
    assign pay_addr_s = ADDR_SIZE'(payload_s);

    // Counter control: load latency on issue, hold count when data lands, else count down.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = '0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            ST_RD_ISSUE: begin
                cnt_load_s = 1'b1;
                cnt_val_s  = CNT_W'(RD_LAT - 1);
            end
            ST_RD_WAIT: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = CNT_W'(TX_HOLD);
                end else begin
                    cnt_dec_s  = 1'b1;
                end
            end
            ST_TX_HOLD: begin
                cnt_dec_s = 1'b1;
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    spi_ram_ctrl_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .is_zero  (cnt_zero_s),
        .is_one   (cnt_one_s)
    );

    // Sequencer FSM with registered RAM strobes, busy and tx outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_addr_r  <= '0;
            rd_addr_r  <= '0;
            rd_armed_r <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= 8'h00;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            // RAM strobes are single-cycle pulses; idle value is all-zero.
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 8'h00;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (opcode_s)
                            OP_WR_ADDR: begin
                                wr_addr_r <= pay_addr_s;
                            end
                            OP_WR_DATA: begin
                                state_r  <= ST_WRITE;
                                busy     <= 1'b1;
                                mem_en   <= 1'b1;
                                mem_we   <= 1'b1;
                                mem_addr <= wr_addr_r;
                                mem_din  <= payload_s;
                            end
                            OP_RD_ADDR: begin
                                rd_addr_r  <= pay_addr_s;
                                rd_armed_r <= 1'b1;
                            end
                            OP_RD_DATA: begin
                                if (rd_armed_r) begin
                                    state_r  <= ST_RD_ISSUE;
                                    busy     <= 1'b1;
                                    mem_en   <= 1'b1;
                                    mem_addr <= rd_addr_r;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                ST_RD_ISSUE: begin
                    state_r <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (cnt_zero_s) begin
                        tx_data    <= mem_dout;
                        tx_valid   <= 1'b1;
                        rd_armed_r <= 1'b0;
                        state_r    <= ST_TX_HOLD;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_TX_HOLD: begin
                    if (cnt_one_s) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r <= ST_TX_HOLD;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_RAM_CTRL_ERR_CNT_EN
    logic err_s;

    // A command is an error when it arrives while busy or reads while unarmed.
    assign err_s = rx_valid &&
                   ((state_r != ST_IDLE) ||
                    ((opcode_s == OP_RD_DATA) && !rd_armed_r));

    // Saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_s && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end else begin
            err_cnt <= err_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl. Two instances (read latency 1
// and 3) receive identical command streams; a transaction-level model
// predicts busy windows, RAM strobes and the tx byte window per instance.
module tb_spi_ram_ctrl;

    localparam int H = 9;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data  = 10'h000;

    logic       tx_valid_w [2];
    logic [7:0] tx_data_w  [2];
    logic       mem_en_w   [2];
    logic       mem_we_w   [2];
    logic [7:0] mem_addr_w [2];
    logic [7:0] mem_din_w  [2];
    logic       busy_w     [2];
`ifdef SPI_RAM_CTRL_ERR_CNT_EN
    logic [7:0] err_w      [2];
`endif

    logic [7:0] pipe0;
    logic [7:0] pipe1 [3];

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(8), .RD_LAT(1), .TX_HOLD(H)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid_w[0]), .tx_data(tx_data_w[0]),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_din(mem_din_w[0]), .mem_dout(pipe0),
`ifdef SPI_RAM_CTRL_ERR_CNT_EN
        .err_cnt(err_w[0]),
`endif
        .busy(busy_w[0])
    );

    spi_ram_ctrl #(.ADDR_SIZE(8), .RD_LAT(3), .TX_HOLD(H)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid_w[1]), .tx_data(tx_data_w[1]),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_din(mem_din_w[1]), .mem_dout(pipe1[2]),
`ifdef SPI_RAM_CTRL_ERR_CNT_EN
        .err_cnt(err_w[1]),
`endif
        .busy(busy_w[1])
    );

    // Power-up RAM content is a fixed address pattern.
    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // RAMs attached to each DUT; unread cycles carry random junk.
    bit [7:0] ram  [2][256];
    bit       ramw [2][256];

    function automatic logic [7:0] ram_rd(input int d, input logic [7:0] a);
        return ramw[d][a] ? ram[d][a] : init_byte(int'(a));
    endfunction

    // RAM behaviour: write on strobe, read data emerges RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (mem_en_w[0] && mem_we_w[0]) begin
            ram[0][mem_addr_w[0]]  <= mem_din_w[0];
            ramw[0][mem_addr_w[0]] <= 1'b1;
        end
        if (mem_en_w[1] && mem_we_w[1]) begin
            ram[1][mem_addr_w[1]]  <= mem_din_w[1];
            ramw[1][mem_addr_w[1]] <= 1'b1;
        end
        pipe0    <= (mem_en_w[0] && !mem_we_w[0]) ? ram_rd(0, mem_addr_w[0]) : 8'($urandom);
        pipe1[0] <= (mem_en_w[1] && !mem_we_w[1]) ? ram_rd(1, mem_addr_w[1]) : 8'($urandom);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end

    // Reference model state, one slot per DUT.
    logic [7:0] m_wr   [2];
    logic [7:0] m_rd   [2];
    bit         m_arm  [2];
    int         m_err  [2];
    int         m_free [2];
    int         m_acc  [2];
    bit         m_we   [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_din  [2];
    int         m_txs  [2];
    int         m_txe  [2];
    logic [7:0] m_cur  [2];
    logic [7:0] m_prev [2];
    logic [7:0] m_mem  [2][256];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 8'h00; m_rd[d] = 8'h00; m_arm[d] = 1'b0; m_err[d] = 0;
            m_free[d] = 0; m_acc[d] = -1; m_we[d] = 1'b0;
            m_addr[d] = 8'h00; m_din[d] = 8'h00;
            m_txs[d] = 0; m_txe[d] = -1; m_cur[d] = 8'h00; m_prev[d] = 8'h00;
        end
    endtask

    task automatic model_accept(input int d, input logic [9:0] data);
        int L;
        L = (d == 0) ? 1 : 3;
        if (cyc < m_free[d]) begin
            m_err[d]++;
        end else begin
            case (data[9:8])
                2'b00: m_wr[d] = data[7:0];
                2'b01: begin
                    m_acc[d] = cyc + 1; m_we[d] = 1'b1;
                    m_addr[d] = m_wr[d]; m_din[d] = data[7:0];
                    m_mem[d][m_wr[d]] = data[7:0];
                    m_free[d] = cyc + 2;
                end
                2'b10: begin
                    m_rd[d] = data[7:0]; m_arm[d] = 1'b1;
                end
                default: begin
                    if (m_arm[d]) begin
                        m_acc[d] = cyc + 1; m_we[d] = 1'b0;
                        m_addr[d] = m_rd[d]; m_din[d] = 8'h00;
                        m_prev[d] = m_cur[d];
                        m_cur[d] = m_mem[d][m_rd[d]];
                        m_txs[d] = cyc + 2 + L;
                        m_txe[d] = cyc + 1 + L + H;
                        m_free[d] = cyc + 2 + L + H;
                        m_arm[d] = 1'b0;
                    end else begin
                        m_err[d]++;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        bit en;
        for (int d = 0; d < 2; d++) begin
            en = (cyc == m_acc[d]);
            check($sformatf("d%0d busy", d), 32'(busy_w[d]), 32'(cyc < m_free[d]));
            check($sformatf("d%0d mem_en", d), 32'(mem_en_w[d]), 32'(en));
            check($sformatf("d%0d mem_we", d), 32'(mem_we_w[d]), 32'(en && m_we[d]));
            check($sformatf("d%0d mem_addr", d), 32'(mem_addr_w[d]), 32'(en ? m_addr[d] : 8'h00));
            check($sformatf("d%0d mem_din", d), 32'(mem_din_w[d]), 32'((en && m_we[d]) ? m_din[d] : 8'h00));
            check($sformatf("d%0d tx_valid", d), 32'(tx_valid_w[d]), 32'((cyc >= m_txs[d]) && (cyc <= m_txe[d])));
            check($sformatf("d%0d tx_data", d), 32'(tx_data_w[d]), 32'((cyc >= m_txs[d]) ? m_cur[d] : m_prev[d]));
`ifdef SPI_RAM_CTRL_ERR_CNT_EN
            check($sformatf("d%0d err_cnt", d), 32'(err_w[d]), 32'((m_err[d] > 255) ? 255 : m_err[d]));
`endif
        end
    endtask

    // One clock: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input bit v, input logic [9:0] data);
        @(negedge clk);
        cyc++;
        check_all();
        rst_n    = 1'b1;
        rx_valid = v;
        rx_data  = data;
        if (v) begin
            for (int d = 0; d < 2; d++) model_accept(d, data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'h000);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        cyc++;
        check_all();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d rst tx_valid", d), 32'(tx_valid_w[d]), 32'd0);
            check($sformatf("d%0d rst busy", d), 32'(busy_w[d]), 32'd0);
            check($sformatf("d%0d rst tx_data", d), 32'(tx_data_w[d]), 32'd0);
        end
        model_reset();
    endtask

    initial begin
        logic [1:0] op;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a++) m_mem[d][a] = init_byte(a);

        // Reset state, then write 0xA5 to 0x3C.
        idle(2);
        step(1'b1, {2'b00, 8'h3C});
        step(1'b1, {2'b01, 8'hA5});
        idle(3);

        // Read back 0x3C.
        step(1'b1, {2'b10, 8'h3C});
        step(1'b1, {2'b11, 8'h00});
        idle(16);

        // Unarmed read is illegal.
        step(1'b1, {2'b11, 8'h00});
        idle(3);

        // Command during the hold window is dropped.
        step(1'b1, {2'b10, 8'h3C});
        step(1'b1, {2'b11, 8'h00});
        idle(5);
        step(1'b1, {2'b01, 8'h77});
        idle(14);

        // Reset in TX_HOLD, then a read without re-arming.
        step(1'b1, {2'b10, 8'h10});
        step(1'b1, {2'b11, 8'h00});
        idle(6);
        do_reset();
        step(1'b1, {2'b11, 8'h00});
        idle(3);

        // Random traffic over a small address window.
        for (int i = 0; i < 600; i++) begin
            op = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 3) == 0), {op, 4'h0, 4'($urandom_range(0, 15))});
        end
        idle(16);

        // Flood of illegal reads drives the error counter into saturation.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, {2'b11, 8'h00});
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
